// File: rtl/decoder_arb.sv
// decoder_arb: round-robin owner of the shared 3-to-8 select decoder (en/sel/grant all registered).
// Optional grant watchdog is compiled in when DECODER_ARB_TIMEOUT_EN is defined.
module decoder_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       CROBAR,
    input  logic [0:7] req,
    input  logic       done,
    output logic       en,
    output logic [0:2] sel,
    output logic [0:7] grant,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("decoder_arb: TIMEOUT must be within 2..255");
    end

    state_t     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [2:0] sel_q, sel_d;
    logic [0:7] grant_q, grant_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;

`ifdef DECODER_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
`endif

    // Circular search starting one past the previous owner, wrapping 7 -> 0.
    logic [2:0] win, idx;
    logic       any_req;
    always_comb begin
        win     = last_q;
        idx     = last_q;
        any_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!any_req && req[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        en_d    = en_q;
        busy_d  = busy_q;
`ifdef DECODER_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = GRANT;
                    last_d       = win;
                    sel_d        = win;
                    en_d         = 1'b1;
                    busy_d       = 1'b1;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
`ifdef DECODER_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            GRANT: begin
                // done outranks the watchdog when both land in the same cycle
                if (done) begin
                    state_d = RECOVER;
                    en_d    = 1'b0;
                    grant_d = '0;
                end
`ifdef DECODER_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = RECOVER;
                    en_d    = 1'b0;
                    grant_d = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RECOVER: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            sel_q   <= '0;
            grant_q <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
`ifdef DECODER_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign en    = en_q;
    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = busy_q;
`ifdef DECODER_ARB_TIMEOUT_EN
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_arb.sv
// Bench for decoder_arb: vector table, directed corner sequences, random run against a behavioural model.
module tb_decoder_arb;
    logic       clk = 1'b0;
    logic       CROBAR = 1'b1;
    logic [0:7] req = '0;
    logic       done = 1'b0;
    logic       en;
    logic [0:2] sel;
    logic [0:7] grant;
    logic       busy;
    logic       timeout;

    localparam int TO = 4;

    always #5 clk = ~clk;

    decoder_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .CROBAR(CROBAR), .req(req), .done(done),
        .en(en), .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model: phase 0 = idle, 1 = owned, 2 = dead cycle.
    int m_st = 0, m_last = 7, m_owner = 0, m_age = 0;
    bit m_to = 0;

    task automatic model_step(input logic rst, input logic [0:7] r, input logic d);
        if (rst) begin
            m_st = 0; m_last = 7; m_owner = 0; m_age = 0; m_to = 0;
            return;
        end
        m_to = 0;
        case (m_st)
            0: begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_st == 0 && r[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        m_last  = m_owner;
                        m_st    = 1;
                        m_age   = 1;
                    end
                end
            end
            1: begin
                if (d) m_st = 2;
`ifdef DECODER_ARB_TIMEOUT_EN
                else if (m_age == TO) begin m_st = 2; m_to = 1; end
`endif
                else m_age++;
            end
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [13:0] pack(logic e, logic [2:0] s, logic [0:7] g, logic b, logic t,
                                         logic show_sel);
        return {e, (show_sel ? s : 3'd0), g, b, t};
    endfunction

    task automatic expect_out(input string nm, input logic e, input logic [2:0] s,
                              input logic [0:7] g, input logic b, input logic t);
        logic [13:0] exp_v, act_v;
        exp_v = pack(e, s, g, b, t, e);
        act_v = pack(en, sel, grant, busy, timeout, e);
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL %s: got {en,sel,grant,busy,to}=%b want %b at %0t", nm, act_v, exp_v, $time);
    endtask

    task automatic step(input logic rst, input logic [0:7] r, input logic d);
        logic [0:7] mg;
        CROBAR = rst; req = r; done = d;
        @(posedge clk);
        model_step(rst, r, d);
        #1;
        mg = '0;
        if (m_st == 1) mg[m_owner] = 1'b1;
        expect_out("model", m_st == 1, 3'(m_owner), mg, m_st != 0, m_to);
    endtask

    typedef struct {
        logic       rst;
        logic [0:7] r;
        logic       d;
        logic       e;
        logic [2:0] s;
        logic [0:7] g;
        logic       b;
        logic       t;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [0:7] g;
        logic [0:7] r;

        tbl[0] = '{1'b1, 8'h00,        1'b0, 1'b0, 3'd0, 8'h00,        1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'b0010_0000, 1'b0, 1'b1, 3'd2, 8'b0010_0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00,        1'b0, 1'b1, 3'd2, 8'b0010_0000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00,        1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00,        1'b0, 1'b0, 3'd0, 8'h00,        1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00,        1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'hFF,        1'b0, 1'b1, 3'd3, 8'b0001_0000, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'hFF,        1'b1, 1'b0, 3'd0, 8'h00,        1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00,        1'b0, 1'b0, 3'd0, 8'h00,        1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'b1000_0001, 1'b0, 1'b1, 3'd7, 8'b0000_0001, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].r, tbl[i].d);
            expect_out($sformatf("vec%0d", i), tbl[i].e, tbl[i].s, tbl[i].g, tbl[i].b, tbl[i].t);
        end

        // Full contention with done in every grant cycle: strict rotation, 3 cycles per handoff.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            g = '0; g[i % 8] = 1'b1;
            step(1'b0, 8'hFF, 1'b1);
            expect_out($sformatf("rr_grant%0d", i), 1'b1, 3'(i % 8), g, 1'b1, 1'b0);
            step(1'b0, 8'hFF, 1'b1);
            expect_out($sformatf("rr_recover%0d", i), 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
            step(1'b0, 8'hFF, 1'b1);
            expect_out($sformatf("rr_idle%0d", i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        end

        // Owner 5 drops req but keeps the grant; requester 6 waits for done.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'b0000_0110, 1'b0);
        expect_out("own5_grant", 1'b1, 3'd5, 8'b0000_0100, 1'b1, 1'b0);
        step(1'b0, 8'b0000_0010, 1'b0);
        expect_out("own5_hold1", 1'b1, 3'd5, 8'b0000_0100, 1'b1, 1'b0);
        step(1'b0, 8'b0000_0010, 1'b0);
        expect_out("own5_hold2", 1'b1, 3'd5, 8'b0000_0100, 1'b1, 1'b0);
        step(1'b0, 8'b0000_0010, 1'b1);
        expect_out("own5_recover", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'b0000_0010, 1'b0);
        expect_out("own5_idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'b0000_0010, 1'b0);
        expect_out("req6_grant", 1'b1, 3'd6, 8'b0000_0010, 1'b1, 1'b0);

        // Reset mid-grant: no dead cycle, pointer back to requester 0.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'b0000_1000, 1'b0);
        expect_out("own4_grant", 1'b1, 3'd4, 8'b0000_1000, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        expect_out("crobar_mid_grant", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        expect_out("after_crobar", 1'b1, 3'd0, 8'b1000_0000, 1'b1, 1'b0);

`ifdef DECODER_ARB_TIMEOUT_EN
        // Watchdog release after TO grant cycles, then done winning the tie.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'b1000_0000, 1'b0);
        for (int i = 1; i < TO; i++) begin
            step(1'b0, 8'b1000_0000, 1'b0);
            expect_out($sformatf("wd_hold%0d", i), 1'b1, 3'd0, 8'b1000_0000, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
        expect_out("wd_fire", 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        expect_out("wd_idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'b1000_0000, 1'b0);
        for (int i = 1; i < TO; i++) step(1'b0, 8'b1000_0000, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        expect_out("wd_done_wins", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
`endif

        // Random traffic against the model.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 800; i++) begin
            r = (i % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            step($urandom_range(0, 63) == 0, r, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decoder_arb.md
# decoder_arb

Round-robin scheduler that shares one 3-to-8 select decoder among eight requesters. Each cycle it picks at most one pending requester, drives the decoder's enable and 3-bit select so that exactly one decoder output line is active for the whole transaction, and holds that grant until the owner signals completion. It sits directly in front of the decoder in the EBOX control path and is the only block allowed to drive the decoder's `en`/`sel` inputs.

## Interface
- `TIMEOUT`, default 16: watchdog limit in cycles for a held grant; used only when `DECODER_ARB_TIMEOUT_EN` is defined; legal range 2..255.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `CROBAR`  input  1  reset; synchronous and active-high.
- `req`  input  [0:7]  request lines; bit 0 is requester 0, the highest priority after reset.
- `done`  input  1  the current owner releases the grant; sampled only in state GRANT.
- `en`  output  1  decoder enable; high only in state GRANT.
- `sel`  output  [0:2]  decoder select, binary index of the owner; `sel` = 0 selects requester 0.
- `grant`  output  [0:7]  one-hot copy of the decoder output pattern: bit `sel` is set when `en` = 1, otherwise all zero.
- `busy`  output  1  high in GRANT and RECOVER.
- `timeout`  output  1  one-cycle pulse when the watchdog forces a release; constant 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, GRANT, RECOVER. All outputs are registered.
- IDLE: if any `req` bit is set, select the winner by circular search starting at `last+1` and wrapping 7→0. Load `sel` with the winner, set `last` to the winner, and go to GRANT. If no bit is set, stay in IDLE.
- GRANT: `en` = 1. `grant` is one-hot on `sel`. `sel` stays stable for the whole state. If the owner drops `req` while `done` = 0, it keeps the grant. If `done` = 1, go to RECOVER.
- RECOVER: exactly one dead cycle with `en` = 0 and `grant` = 0, then return to IDLE. This guarantees the decoder output is deasserted between owners.
- `done` is ignored in IDLE and RECOVER.
- Requests are not latched. A requester that drops `req` before it is sampled in IDLE loses its turn.
- Fairness: a requester that holds `req` high waits at most 7 other transactions.
- Reset values: state = IDLE, `last` = 7 (so the first search starts at requester 0), `sel` = 0, `en` = 0, `grant` = 0, `busy` = 0, `timeout` = 0, watchdog count = 0.
- `CROBAR` asserted in any state, including mid-GRANT, returns every register to its reset value on that edge. There is no RECOVER cycle after a reset.

## Timing
- Request to grant: `req` high in IDLE at edge N gives `en` = 1 from edge N+1.
- `done` high in GRANT at edge M gives `en` = 0 from edge M+1, IDLE from M+2, and the next grant at the earliest from M+3.
- Back-to-back transactions therefore take at least 3 cycles per handoff, counting GRANT(1) + RECOVER(1) + IDLE(1).
- A single-cycle transaction, where `done` is already high in the first GRANT cycle, is legal.
- `en`, `sel` and `grant` change only on state transitions. No glitch sources exist because all outputs come from flops.

## Configuration
- `DECODER_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to GRANT and increments every GRANT cycle while `done` = 0.
  - When the count reaches `TIMEOUT`-1 with `done` = 0, the next edge goes to RECOVER and pulses `timeout` = 1 for that one cycle.
  - If `done` and the limit occur in the same cycle, `done` wins and `timeout` stays 0.
- `DECODER_ARB_TIMEOUT_EN` not defined: no counter exists, `timeout` is tied to 0, and a grant is held indefinitely until `done`.

## Test plan
- Reset, then `req` = 8'b0010_0000 (requester 2) -> next cycle `en` = 1, `sel` = 2, `grant` = 8'b0010_0000, `busy` = 1. After `done` the outputs are `en` = 0 (RECOVER), then IDLE.
- `req` = 8'hFF held with `done` pulsed in every GRANT -> `sel` sequence 0,1,2,…,7,0, with exactly one RECOVER cycle and one IDLE cycle between grants.
- Owner 5 drops `req` in its second GRANT cycle with `done` = 0 -> `en`/`sel` = 5 held. Requester 6 pending -> granted only after `done`, 3 cycles later.
- `CROBAR` asserted during GRANT of requester 4 -> next cycle all outputs are 0 and state is IDLE. With `req` = 8'hFF, the next grant is `sel` = 0.
- With `DECODER_ARB_TIMEOUT_EN`, `TIMEOUT` = 4, `done` held 0 -> `en` high for exactly 4 cycles, then `timeout` = 1 for one cycle together with RECOVER. Repeat with `done` = 1 on cycle 4 -> `timeout` stays 0.
- `done` asserted while IDLE with `req` = 0 -> no state change and all outputs remain 0.
